// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/lap/clear controller with a packed-BCD mm:ss.hh time base.
// Optional build macro STOPWATCH_SATURATE_EN: hold at MIN_MAX:59.99 instead of wrapping.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 500000,
  parameter int MIN_MAX  = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [7:0] ms_bcd,
  output logic [7:0] s_bcd,
  output logic [7:0] min_bcd,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  localparam int                PSC_W    = $clog2(TICK_DIV);
  localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(TICK_DIV - 1);
  localparam logic [7:0]        MIN_TOP  = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
  localparam logic [23:0]       TIME_TOP = {MIN_TOP, 8'h59, 8'h99};

  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

  state_t           state_q, state_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [23:0]      live_q, live_d, snap_q, snap_d, live_inc, disp_d;
  logic [7:0]       ms_n, s_n, m_n;
  logic             c_ms, c_s, c_m, wrap_ev, ovf_d, counting, tick;

  // Two-digit BCD increment: returns {carry_out, next}; wraps to 00 after top.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      bcd_inc = 9'h100;
    else if (v[3:0] == 4'd9)
      bcd_inc = {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      bcd_inc = {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (psc_q == PSC_LAST);

  // Whole carry chain resolves in one cycle.
  always_comb begin
    {c_ms, ms_n} = bcd_inc(live_q[7:0],   8'h99);
    {c_s,  s_n}  = bcd_inc(live_q[15:8],  8'h59);
    {c_m,  m_n}  = bcd_inc(live_q[23:16], MIN_TOP);
    wrap_ev      = c_ms && c_s && c_m;
    live_inc     = live_q;
    live_inc[7:0] = ms_n;
    if (c_ms) live_inc[15:8] = s_n;
    if (c_ms && c_s) live_inc[23:16] = m_n;
`ifdef STOPWATCH_SATURATE_EN
    if (wrap_ev) live_inc = TIME_TOP;
`endif
  end

  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    live_d  = live_q;
    snap_d  = snap_q;
    ovf_d   = ovf;
    // Counting follows the pre-edge state, so a tick on a RUN->STOP edge still lands.
    if (counting) psc_d = tick ? '0 : psc_q + 1'b1;
    if (tick) begin
      live_d = live_inc;
      ovf_d  = ovf || wrap_ev;
    end
    if (clear) begin
      state_d = IDLE;
      psc_d   = '0;
      live_d  = '0;
      snap_d  = '0;
      ovf_d   = 1'b0;
    end else if (start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = STOP;
        LAP:     state_d = STOP;
        STOP:    state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (lap) begin
      if (state_q == RUN) begin
        state_d = LAP;
        snap_d  = live_q;
      end else if (state_q == LAP) begin
        state_d = RUN;
      end
    end
    disp_d = (state_d == LAP) ? snap_d : live_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      psc_q      <= '0;
      live_q     <= '0;
      snap_q     <= '0;
      ovf        <= 1'b0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      min_bcd    <= 8'h00;
      s_bcd      <= 8'h00;
      ms_bcd     <= 8'h00;
    end else begin
      state_q    <= state_d;
      psc_q      <= psc_d;
      live_q     <= live_d;
      snap_q     <= snap_d;
      ovf        <= ovf_d;
      running    <= (state_d == RUN) || (state_d == LAP);
      lap_active <= (state_d == LAP);
      {min_bcd, s_bcd, ms_bcd} <= disp_d;
    end
  end

endmodule
